// File: rtl/tdes_pkg.sv
// Shared widths, FSM encodings, permutation tables and helpers for the DES key schedule store.
package tdes_pkg;

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned SK_W   = 48;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned CD_W   = 56;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  // Left-rotation amount of C/D before each round's PC-2
  localparam int unsigned SHIFT_TABLE [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Source bit numbers (1 = MSB) for each PC-1 output bit, C half then D half
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Source bit numbers (1 = MSB of {C,D}) for each PC-2 output bit
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // PC-1: 64-bit key (parity bits dropped) to 56-bit {C,D}
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[CD_W-1-i] = key[KEY_W-PC1_TAB[i]];
    end
    return cd;
  endfunction

  // PC-2: 56-bit {C,D} to 48-bit round subkey
  function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SK_W-1:0] sk;
    sk = '0;
    for (int i = 0; i < 48; i++) begin
      sk[SK_W-1-i] = cd[CD_W-PC2_TAB[i]];
    end
    return sk;
  endfunction

  // High when any byte of the key fails odd parity
  function automatic logic parity_bad(input logic [KEY_W-1:0] key);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bad = bad | ~(^key[8*b +: 8]);
    end
    return bad;
  endfunction

endpackage

// File: rtl/des_cd_step.sv
// One key-schedule step: rotate C and D left by 1 or 2 and derive the round subkey.
module des_cd_step
  import tdes_pkg::*;
(
  input  logic [HALF_W-1:0] c_in,
  input  logic [HALF_W-1:0] d_in,
  input  logic              shift_one,
  output logic [HALF_W-1:0] c_next_c,
  output logic [HALF_W-1:0] d_next_c,
  output logic [SK_W-1:0]   subkey_c
);

  // Rotate both halves, then PC-2 on the rotated pair
  always_comb begin
    c_next_c = c_in;
    d_next_c = d_in;
    if (shift_one) begin
      c_next_c = {c_in[HALF_W-2:0], c_in[HALF_W-1]};
      d_next_c = {d_in[HALF_W-2:0], d_in[HALF_W-1]};
    end else begin
      c_next_c = {c_in[HALF_W-3:0], c_in[HALF_W-1:HALF_W-2]};
      d_next_c = {d_in[HALF_W-3:0], d_in[HALF_W-1:HALF_W-2]};
    end
    subkey_c = pc2({c_next_c, d_next_c});
  end

endmodule

// File: rtl/tdes_keysched_store.sv
// Expands a bundle of DES keys into a subkey store, one subkey per cycle, and serves
// subkeys by (key, round, direction) with one cycle of read latency.
module tdes_keysched_store
  import tdes_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 3,
  parameter int unsigned ROUNDS   = 16,
  localparam int unsigned KSEL_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_valid,
  output logic                      key_ready,
  input  logic [KEY_W*NUM_KEYS-1:0] key_data,
  output logic                      sched_ready,
  output logic [NUM_KEYS-1:0]       parity_err,
  input  logic                      sk_req,
  input  logic [KSEL_W-1:0]         sk_key_sel,
  input  logic [3:0]                sk_round,
  input  logic                      sk_decrypt,
  output logic                      sk_valid,
  output logic [SK_W-1:0]           sk_data,
  output logic                      sk_err
);

  localparam int unsigned RND_W = $clog2(ROUNDS);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              accept_c;
  logic              last_write_c;
  logic [KSEL_W-1:0] key_cnt;
  logic [RND_W-1:0]  rnd_cnt;

  logic [HALF_W-1:0] c_reg [NUM_KEYS];
  logic [HALF_W-1:0] d_reg [NUM_KEYS];
  logic [SK_W-1:0]   store [NUM_KEYS][ROUNDS];

  logic [CD_W-1:0]     pc1_c [NUM_KEYS];
  logic [NUM_KEYS-1:0] parity_c;

  logic              shift_one_c;
  logic [HALF_W-1:0] c_nxt_c;
  logic [HALF_W-1:0] d_nxt_c;
  logic [SK_W-1:0]   subkey_c;

  logic [RND_W-1:0]  rd_round_c;
  logic              rd_ok_c;

  // Bundles are only taken outside expansion; depends on state alone
  assign key_ready = (state == ST_IDLE) || (state == ST_READY);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, accept strobe and last-write detection
  always_comb begin
    state_nxt    = state;
    accept_c     = 1'b0;
    last_write_c = 1'b0;
    case (state)
      ST_IDLE, ST_READY: begin
        if (key_valid) begin
          accept_c  = 1'b1;
          state_nxt = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (key_cnt == KSEL_W'(NUM_KEYS - 1) && rnd_cnt == RND_W'(ROUNDS - 1)) begin
          last_write_c = 1'b1;
          state_nxt    = ST_READY;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-key PC-1 and parity of the offered bundle; key 0 sits in the top 64 bits
  always_comb begin
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      pc1_c[k]    = pc1(key_data[KEY_W*(NUM_KEYS-k)-1 -: KEY_W]);
      parity_c[k] = parity_bad(key_data[KEY_W*(NUM_KEYS-k)-1 -: KEY_W]);
    end
  end

  assign shift_one_c = (SHIFT_TABLE[rnd_cnt] == 1);

  des_cd_step u_step (
    .c_in     (c_reg[key_cnt]),
    .d_in     (d_reg[key_cnt]),
    .shift_one(shift_one_c),
    .c_next_c (c_nxt_c),
    .d_next_c (d_nxt_c),
    .subkey_c (subkey_c)
  );

  // C/D registers and key/round counters
  always_ff @(posedge clk) begin
    if (rst) begin
      key_cnt <= '0;
      rnd_cnt <= '0;
    end else if (accept_c) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        c_reg[k] <= pc1_c[k][CD_W-1:HALF_W];
        d_reg[k] <= pc1_c[k][HALF_W-1:0];
      end
      key_cnt <= '0;
      rnd_cnt <= '0;
    end else if (state == ST_EXPAND) begin
      c_reg[key_cnt] <= c_nxt_c;
      d_reg[key_cnt] <= d_nxt_c;
      if (rnd_cnt == RND_W'(ROUNDS - 1)) begin
        rnd_cnt <= '0;
        key_cnt <= key_cnt + KSEL_W'(1);
      end else begin
        rnd_cnt <= rnd_cnt + RND_W'(1);
      end
    end
  end

  // Subkey store write port
  always_ff @(posedge clk) begin
    if (!rst && state == ST_EXPAND) begin
      store[key_cnt][rnd_cnt] <= subkey_c;
    end
  end

  // Decrypt walks the schedule backwards; out-of-range keys or a stale store are refused
  assign rd_round_c = sk_decrypt ? (RND_W'(ROUNDS - 1) - RND_W'(sk_round)) : RND_W'(sk_round);
  assign rd_ok_c    = sched_ready && ({1'b0, sk_key_sel} < (KSEL_W + 1)'(NUM_KEYS));

  // Status flags and the registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      sched_ready <= 1'b0;
      parity_err  <= '0;
      sk_valid    <= 1'b0;
      sk_data     <= '0;
      sk_err      <= 1'b0;
    end else begin
      if (accept_c) begin
        sched_ready <= 1'b0;
        parity_err  <= parity_c;
      end else if (last_write_c) begin
        sched_ready <= 1'b1;
      end
      sk_valid <= sk_req;
      if (sk_req) begin
        if (rd_ok_c) begin
          sk_data <= store[sk_key_sel][rd_round_c];
          sk_err  <= 1'b0;
        end else begin
          sk_data <= '0;
          sk_err  <= 1'b1;
        end
      end else begin
        sk_err <= 1'b0;
      end
    end
  end

endmodule
